// File: rtl/core_rf_pkg.sv
// Shared types, default sizes and the parity helper for the Selen integer register file.
// Parity storage is compiled in only when CORE_RF_PARITY_EN is defined.
package core_rf_pkg;

    localparam int unsigned RF_DATA_W       = 32;
    localparam int unsigned RF_ADDR_W       = 5;
    localparam int unsigned RF_PARITY_MAX_W = 64;

    typedef enum logic {
        INIT,
        READY
    } rf_state_t;

    // Even parity over a zero-extended word; callers must keep DATA_W <= RF_PARITY_MAX_W.
    function automatic logic rf_parity(input logic [RF_PARITY_MAX_W-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/core_rf_init_ctrl.sv
// Post-reset clear sequencer: walks every register address once, then parks in READY
// until the next reset.
module core_rf_init_ctrl
    import core_rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    rf_state_t         state;
    rf_state_t         state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Terminal count is compared explicitly so the counter never relies on wrapping.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            INIT: begin
                if (cnt == LAST_ADDR) begin
                    state_next = READY;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = INIT;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        init_we   = (state == INIT);
        init_addr = cnt;
        init_done = (state == READY);
    end

endmodule

// File: rtl/core_reg_file_init.sv
// Selen integer register file: 2R/1W, registered reads with write-first bypass, optional
// hardwired zero register and a hardware clear after reset. Parity: CORE_RF_PARITY_EN.
module core_reg_file_init
    import core_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] data_in,
    input  logic              we,
    input  logic              order,
    output logic [DATA_W-1:0] src1_out_r,
    output logic [DATA_W-1:0] src2_out_r,
    output logic              init_done
`ifdef CORE_RF_PARITY_EN
    ,
    output logic              parity_err_r
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef CORE_RF_PARITY_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic              wr_en;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry1;
    logic [ENTRY_W-1:0] rd_entry2;
    logic              zero1;
    logic              zero2;
    logic              byp1;
    logic              byp2;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;

    core_rf_init_ctrl #(
        .ADDR_W(ADDR_W)
    ) u_init_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_we  (init_we),
        .init_addr(init_addr),
        .init_done(init_done)
    );

    always_comb begin
        wr_en = we && init_done && !(ZERO_REG && (rd == '0));
`ifdef CORE_RF_PARITY_EN
        wr_entry = {rf_parity(RF_PARITY_MAX_W'(data_in)), data_in};
`else
        wr_entry = data_in;
`endif
    end

    // The clear sequence owns the write port until init_done, so user writes are dropped.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= '0;
        end else if (wr_en) begin
            mem[rd] <= wr_entry;
        end
    end

    always_comb begin
        rd_entry1 = mem[rs1];
        rd_entry2 = mem[rs2];
        zero1     = ZERO_REG && (rs1 == '0);
        zero2     = ZERO_REG && (rs2 == '0);
        byp1      = we && (rd == rs1);
        byp2      = we && (rd == rs2);

        if (zero1) begin
            val1 = '0;
        end else if (byp1) begin
            val1 = data_in;
        end else begin
            val1 = rd_entry1[DATA_W-1:0];
        end

        if (zero2) begin
            val2 = '0;
        end else if (byp2) begin
            val2 = data_in;
        end else begin
            val2 = rd_entry2[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src1_out_r <= '0;
            src2_out_r <= '0;
        end else if (!init_done) begin
            src1_out_r <= '0;
            src2_out_r <= '0;
        end else if (order) begin
            src1_out_r <= val2;
            src2_out_r <= val1;
        end else begin
            src1_out_r <= val1;
            src2_out_r <= val2;
        end
    end

`ifdef CORE_RF_PARITY_EN
    logic perr1;
    logic perr2;

    // Only reads served from the array are checked; bypass and zero-register reads carry no parity.
    always_comb begin
        perr1 = !zero1 && !byp1 &&
                (rd_entry1[DATA_W] != rf_parity(RF_PARITY_MAX_W'(rd_entry1[DATA_W-1:0])));
        perr2 = !zero2 && !byp2 &&
                (rd_entry2[DATA_W] != rf_parity(RF_PARITY_MAX_W'(rd_entry2[DATA_W-1:0])));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= init_done && (perr1 || perr2);
        end
    end
`endif

endmodule

// File: tb/tb_core_reg_file_init.sv
// Randomized self-checking bench for core_reg_file_init against an array-based reference.
// Parity checks are included when CORE_RF_PARITY_EN is defined.
module tb_core_reg_file_init;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] rs1 = '0;
    logic [ADDR_W-1:0] rs2 = '0;
    logic [ADDR_W-1:0] rd = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic              we = 1'b0;
    logic              order = 1'b0;
    logic [DATA_W-1:0] src1_out_r;
    logic [DATA_W-1:0] src2_out_r;
    logic              init_done;
`ifdef CORE_RF_PARITY_EN
    logic              parity_err_r;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] model [DEPTH];

    core_reg_file_init #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .data_in   (data_in),
        .we        (we),
        .order     (order),
        .src1_out_r(src1_out_r),
        .src2_out_r(src2_out_r),
        .init_done (init_done)
`ifdef CORE_RF_PARITY_EN
        ,
        .parity_err_r(parity_err_r)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Register 0 reads zero; a same-cycle write to the address is seen; otherwise stored value.
    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a, input logic w,
                                                   input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] d);
        if (a == 0) return '0;
        if (w && wa == a) return d;
        return model[a];
    endfunction

    task automatic step(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                        input logic [ADDR_W-1:0] w_addr, input logic w,
                        input logic [DATA_W-1:0] d, input logic ord, input string tag);
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
        rs1 = a1; rs2 = a2; rd = w_addr; we = w; data_in = d; order = ord;
        v1 = ref_read(a1, w, w_addr, d);
        v2 = ref_read(a2, w, w_addr, d);
        @(posedge clk);
        #1;
        if (w && w_addr != 0) model[w_addr] = d;
        check({tag, "_src1"}, src1_out_r, ord ? v2 : v1);
        check({tag, "_src2"}, src2_out_r, ord ? v1 : v2);
`ifdef CORE_RF_PARITY_EN
        check({tag, "_perr"}, 32'(parity_err_r), 32'd0);
`endif
        we = 1'b0;
    endtask

    // Keeps issuing writes to r5 during the clear; they must be lost and outputs must stay 0.
    task automatic wait_init(input string tag);
        int cyc;
        bit leak;
        cyc = 0;
        leak = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            rd = 5; we = 1'b1; data_in = $urandom; rs1 = 5; rs2 = ADDR_W'($urandom_range(0, DEPTH - 1));
            @(posedge clk);
            #1;
            if (src1_out_r != 0 || src2_out_r != 0) leak = 1'b1;
            if (init_done) begin
                cyc = i;
                break;
            end
        end
        we = 1'b0;
        check({tag, "_init_cycles"}, 32'(cyc), 32'd32);
        check({tag, "_src_zero_in_init"}, 32'(leak), 32'd0);
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
    endtask

    initial begin
        #12;
        check("rst_src1", src1_out_r, '0);
        check("rst_src2", src2_out_r, '0);
        check("rst_init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("por");

        for (int a = 0; a < DEPTH; a++)
            step(ADDR_W'(a), ADDR_W'(DEPTH - 1 - a), '0, 1'b0, '0, 1'($urandom), "clear");

        step(0, 0, 5, 1'b1, 32'hDEADBEEF, 1'b0, "wr_r5");
        step(5, 0, 0, 1'b0, '0, 1'b0, "rd_r5_ord0");
        step(5, 0, 0, 1'b0, '0, 1'b1, "rd_r5_ord1");
        step(7, 7, 7, 1'b1, 32'h12345678, 1'b0, "bypass_r7");
        step(7, 7, 0, 1'b0, '0, 1'b0, "rd_r7");
        step(0, 5, 0, 1'b1, 32'hFFFFFFFF, 1'b0, "wr_r0");
        step(0, 0, 0, 1'b0, '0, 1'b0, "rd_r0");
        step(0, 0, 0, 1'b1, 32'hFFFFFFFF, 1'b1, "byp_r0");

        for (int i = 0; i < 400; i++)
            step(ADDR_W'($urandom_range(0, DEPTH - 1)), ADDR_W'($urandom_range(0, DEPTH - 1)),
                 ADDR_W'($urandom_range(0, DEPTH - 1)), ($urandom_range(0, 3) != 0),
                 $urandom, 1'($urandom), "rand");

        step(5, 5, 5, 1'b1, 32'hCAFEF00D, 1'b0, "pre_rst_wr_r5");
        #2;
        rst_n = 1'b0; we = 1'b1; rd = 5; data_in = 32'h0BADF00D;
        #1;
        check("mid_rst_src1", src1_out_r, '0);
        check("mid_rst_src2", src2_out_r, '0);
        check("mid_rst_init_done", 32'(init_done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("mid");
        step(5, 7, 0, 1'b0, '0, 1'b0, "post_rst_r5");
        step(9, 31, 0, 1'b0, '0, 1'b1, "post_rst_misc");

`ifdef CORE_RF_PARITY_EN
        step(0, 0, 9, 1'b1, 32'hA5A50F0F, 1'b0, "wr_r9");
        step(0, 0, 10, 1'b1, 32'h13572468, 1'b0, "wr_r10");
        rs1 = 9; rs2 = 10; we = 1'b0; order = 1'b0;
        dut.mem[9][4] = ~dut.mem[9][4];
        @(posedge clk);
        #1;
        check("perr_r9", 32'(parity_err_r), 32'd1);
        rs1 = 10; rs2 = 10;
        @(posedge clk);
        #1;
        check("perr_r10_clean", 32'(parity_err_r), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_reg_file_init.md
Name: core_reg_file_init

Overview:
- Parametrised, next-generation integer register file for the Selen core.
- Two read ports and one write port, with an operand-swap control.
- Adds registered posedge reads, write-to-read bypass, a hardwired zero register, and a hardware init sequencer that clears every entry after reset.
- Sits between decode (read addresses) and writeback (rd/data) in the core pipeline.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- ZERO_REG, 1, when 1, entry 0 always reads 0 and writes to it are dropped.

Ports:
- clk  input  1  core clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rs1  input  ADDR_W  read address, port 1.
- rs2  input  ADDR_W  read address, port 2.
- rd  input  ADDR_W  write address.
- data_in  input  DATA_W  write data.
- we  input  1  write enable.
- order  input  1  when 1, swaps the two source outputs.
- src1_out_r  output  DATA_W  registered operand 1.
- src2_out_r  output  DATA_W  registered operand 2.
- init_done  output  1  high once the clear sequence has finished; the file is usable from then on.

Behaviour:
- Reset: asynchronous, active-low.
  - Asserting rst_n=0 immediately forces src1_out_r=0, src2_out_r=0, init_done=0, state=INIT, init counter=0.
  - Array contents are not reset directly; the INIT sequence clears them.
- State INIT:
  - Each cycle, writes 0 to entry cnt, then cnt++.
  - When cnt==2**ADDR_W-1 is written, moves to READY.
  - init_done goes high on the same edge that enters READY, i.e. 2**ADDR_W cycles after rst_n releases.
  - we is ignored during INIT, and src outputs are held at 0.
- State READY (terminal until the next reset):
  - Write: on the rising edge, if we=1 and not (ZERO_REG && rd==0), mem[rd] <= data_in.
  - Read: one-cycle latency. On each rising edge, each port captures its value, determined in this priority order:
    - 0 if ZERO_REG and the address is 0;
    - otherwise data_in if we=1 and rd equals that address (bypass, write-first);
    - otherwise mem[address].
  - order=0: src1_out_r <= value(rs1), src2_out_r <= value(rs2).
  - order=1: src1_out_r <= value(rs2), src2_out_r <= value(rs1).
- Simultaneous events:
  - rs1==rs2==rd with we=1: both ports return data_in.
  - Write to 0 with ZERO_REG=1: dropped, and not bypassed.
- Reset mid-INIT or mid-READY: immediate return to INIT with cnt=0; the full clear is repeated.
- Counter width is ADDR_W; the terminal-count compare avoids relying on wrap-around.

Optional Feature:
- Macro: CORE_RF_PARITY_EN.
- When defined:
  - Each entry stores DATA_W+1 bits; the extra bit is the even parity of data_in, and INIT writes parity 0.
  - New output parity_err_r (1 bit, reset 0) is registered alongside the src outputs.
  - parity_err_r is set for one cycle when either port's non-bypassed, non-zero-register read has a stored parity mismatch.
- When undefined: no extra storage and no parity_err_r port.

Decomposition:
- Package core_rf_pkg:
  - rf_state_t enum {INIT, READY};
  - default DATA_W/ADDR_W localparams;
  - a parity function.
- Sub-module core_rf_init_ctrl:
  - contains the INIT/READY FSM and clear counter;
  - outputs init_we, init_addr, init_done;
  - ports clk, rst_n.
- The array, bypass and swap logic stay in the top module.

Test Plan:
- Release rst_n and count cycles.
  - Required: init_done rises exactly 32 cycles after release (defaults).
  - Then read every address: all return 0x0000_0000.
- Write 0xDEADBEEF to r5, then read rs1=5, rs2=0 with order=0.
  - Required: src1_out_r=0xDEADBEEF, src2_out_r=0 one cycle later.
  - Repeat with order=1: outputs are swapped.
- Same-cycle we=1, rd=7, data_in=0x12345678, rs1=rs2=7.
  - Required: both outputs = 0x12345678 next cycle.
- Write 0xFFFFFFFF to r0 (ZERO_REG=1), then read r0.
  - Required: returns 0.
  - Same-cycle bypass to r0 also returns 0.
- Pull rst_n low for 1 cycle in READY, mid-write stream.
  - Required: outputs go to 0 immediately and init_done drops.
  - After 32 cycles, the previously written r5 reads 0; writes issued during INIT are lost.
- With CORE_RF_PARITY_EN defined, force-flip one stored bit of r9 and read r9.
  - Required: parity_err_r=1 for exactly one cycle.
  - A clean read of r10 gives parity_err_r=0.
